flatten_serializer: RTL and testbench
=====================================

# flatten_serializer

Parametrised parallel-to-serial flatten stage between the global-average-pool bank and the fully-connected unit. It captures one CH-channel vector per `in_valid` pulse into a two-bank (ping-pong) buffer, so a second vector can arrive while the first is still streaming out. It then emits the vector one channel per beat on a ready/valid stream with index and last markers. Vectors that arrive while both banks are full are dropped and flagged.

## Interface
- `CH`, default 32: channels per vector; legal range 2..256.
- `DATA_W`, default 8: bits per channel element.
- `ORDER`, default 0: 0 emits channel 0 first; 1 emits channel CH-1 first.
- `IDX_W`, derived localparam = $clog2(CH): not overridable.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  one-cycle strobe: `in_data` holds a complete vector.
- `in_data`  in  CH*DATA_W  packed vector; channel k occupies bits [k*DATA_W +: DATA_W].
- `in_ready`  out  1  high when at least one bank is free.
- `out_valid`  out  1  current beat is valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  DATA_W  channel element of the current beat.
- `out_idx`  out  IDX_W  channel number of the current beat.
- `out_last`  out  1  current beat is the final channel of the vector.
- `overflow`  out  1  one-cycle pulse: an incoming vector was dropped.
- `busy`  out  1  at least one bank is occupied.

## Operation
- Storage is two banks, each CH x DATA_W.
- Control registers:
  - `wr_bank` (1 bit)
  - `rd_bank` (1 bit)
  - `occ` (0..2)
  - `beat` (IDX_W bits, a beat counter always counting 0..CH-1)
- Occupancy states:
  - EMPTY (`occ`=0)
  - ONE (`occ`=1)
  - FULL (`occ`=2)
- Combinational outputs:
  - `in_ready` = (`occ` != 2). There is no same-cycle bypass: in FULL, `in_ready` stays 0 even when the last beat is accepted in that cycle.
  - `out_valid` = (`occ` != 0). `busy` = `out_valid`.
- Capture: `in_valid && in_ready` writes all CH elements into bank `wr_bank`, then toggles `wr_bank`.
- Drop: `in_valid && !in_ready` discards the vector, leaves all state untouched, and pulses `overflow` high for the next cycle (registered).
- Beat mapping:
  - `out_idx` = `beat` when ORDER=0, and CH-1-`beat` when ORDER=1.
  - `out_data` = bank[`rd_bank`][`out_idx`].
  - `out_last` = `out_valid` && (`beat` == CH-1).
- Advance: `out_valid && out_ready` increments `beat`.
  - On the last beat, `beat` wraps to 0, `rd_bank` toggles and the bank is released.
- `occ` update:
  - +1 on capture.
  - -1 on release.
  - Unchanged when both occur in the same cycle.
- The consumer may hold `out_ready` low indefinitely. While stalled, `out_data`, `out_idx` and `out_last` are stable.
- Bank contents are never cleared. Data from a released bank is unobservable because `out_valid` is 0 for it.

## Timing
- Reset (asynchronous, immediate) sets:
  - `occ`=0, `wr_bank`=0, `rd_bank`=0, `beat`=0
  - `overflow`=0, `out_valid`=0, `out_last`=0, `in_ready`=1, `busy`=0
  - `out_idx`=0 for ORDER=0 and CH-1 for ORDER=1
  - `out_data`=0, because bank storage resets to 0
- Reset mid-stream aborts the vector; nothing is resumed.
- Latency: a vector captured at edge N produces its first beat with `out_valid`=1 in the cycle after edge N.
- With `out_ready` held at 1, one vector takes exactly CH cycles. Back-to-back vectors stream with no bubble between the last beat of one and the first beat of the next.
- Minimum vector spacing for lossless operation with `out_ready`=1:
  - Two vectors may be accepted back to back; the second lands in the free bank.
  - A third vector must not arrive until the cycle after the first vector's last beat completes.
- `overflow` is asserted exactly one cycle per dropped vector. Two consecutive drops produce two consecutive high cycles.

## Structure
- Shared package `cnn_pkg` holds:
  - the default `CH` and `DATA_W` constants, so the pool bank, this block and the FC unit agree;
  - the occupancy state enum (EMPTY, ONE, FULL).
- One sub-module, `flatten_bank`: CH x DATA_W register file with a one-cycle parallel load (`load`, packed `din`) and a combinational indexed read (`rd_idx` -> `dout`), with asynchronous reset to 0.
- `flatten_serializer` instantiates two `flatten_bank` instances plus the control logic.

## Test plan
Default stimulus: CH=32, DATA_W=8, vector elements k+1 unless stated.
- **Basic stream.** ORDER=0, `out_ready`=1, one vector. Expect 32 beats with `out_data` 1..32 and `out_idx` 0..31; `out_last` high only on beat 31; `busy` falls after it.
- **Reverse order.** ORDER=1, same vector. Expect `out_data` 32 down to 1 and `out_idx` 31 down to 0; `out_last` on the beat with `out_idx`=0.
- **Ping-pong.** Vector A (k+1) and vector B (k+101) on consecutive cycles, `out_ready`=1. Expect 64 gap-free beats, A then B. `in_ready` is 0 from the cycle after B is captured until A's last beat has been accepted.
- **Overflow.** Hold `out_ready`=0; send A, B, then C. Expect `overflow` pulsed exactly once and C never emitted; after releasing `out_ready`, A then B stream intact.
- **Backpressure.** Toggle `out_ready` 1,0,0,1,... during a vector. Expect no beat lost or duplicated, and outputs stable while stalled.
- **Reset mid-stream.** Assert `rst_n` low at beat 10. Expect all outputs at reset values immediately; a fresh vector afterwards streams from `out_idx` 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Constants and types shared by the pool bank, the flatten stage and the FC unit.
// Every block that exchanges channel vectors takes its default CH and DATA_W from here.
package cnn_pkg;

  localparam int CNN_CH     = 32;
  localparam int CNN_DATA_W = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Index width for a vector of ch channels; one bit minimum.
  function automatic int idx_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/flatten_bank.sv
// One ping-pong bank: a CH x DATA_W register file.
// It loads a whole vector in one cycle and reads one element combinationally by index.
module flatten_bank
  import cnn_pkg::*;
#(
  parameter  int CH     = CNN_CH,
  parameter  int DATA_W = CNN_DATA_W,
  localparam int IDX_W  = idx_width(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CH*DATA_W-1:0] din,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DATA_W-1:0]    dout
);

  logic [CH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    mem <= '0;
    else if (load) mem <= din;
  end

  // rd_idx never exceeds CH-1, so a non-power-of-two CH never reads past the array.
  assign dout = mem[rd_idx];

endmodule

// File: rtl/flatten_serializer.sv
// Parallel-to-serial flatten stage. A ping-pong pair of banks captures whole vectors,
// and the active bank streams out one channel per beat with index and last markers.
module flatten_serializer
  import cnn_pkg::*;
#(
  parameter  int CH     = CNN_CH,
  parameter  int DATA_W = CNN_DATA_W,
  parameter  int ORDER  = 0,
  localparam int IDX_W  = idx_width(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 overflow,
  output logic                 busy
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(CH - 1);

  occ_e                      occ_q, occ_d;
  logic                      wr_bank_q, rd_bank_q;
  logic [IDX_W-1:0]          beat_q;
  logic                      overflow_q;
  logic                      cap, drop, adv, rel;
  logic [1:0]                load;
  logic [1:0][DATA_W-1:0]    bank_dout;
  logic [IDX_W-1:0]          rd_idx;

  // Handshake qualifiers
  assign cap  = in_valid && in_ready;
  assign drop = in_valid && !in_ready;
  assign adv  = out_valid && out_ready;
  assign rel  = adv && (beat_q == LAST_BEAT);

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  // Occupancy next state; a capture and a release in the same cycle cancel out.
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: if (cap) occ_d = OCC_ONE;
      OCC_ONE: begin
        if (cap && !rel)      occ_d = OCC_FULL;
        else if (rel && !cap) occ_d = OCC_EMPTY;
      end
      OCC_FULL:  if (rel) occ_d = OCC_ONE;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // Outputs decoded from occupancy and the beat counter
  always_comb begin
    in_ready  = (occ_q != OCC_FULL);
    out_valid = (occ_q != OCC_EMPTY);
    busy      = out_valid;
    out_last  = out_valid && (beat_q == LAST_BEAT);
    rd_idx    = (ORDER != 0) ? (LAST_BEAT - beat_q) : beat_q;
    out_idx   = rd_idx;
  end

  // Bank pointers, beat counter and the registered drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop;
      if (cap) wr_bank_q <= ~wr_bank_q;
      if (adv) begin
        if (rel) begin
          beat_q    <= '0;
          rd_bank_q <= ~rd_bank_q;
        end else begin
          beat_q    <= beat_q + IDX_W'(1);
        end
      end
    end
  end

  assign overflow = overflow_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign load[b] = cap && (wr_bank_q == 1'(b));

    flatten_bank #(
      .CH     (CH),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[b]),
      .din    (in_data),
      .rd_idx (rd_idx),
      .dout   (bank_dout[b])
    );
  end

  assign out_data = bank_dout[rd_bank_q];

endmodule

// File: tb/tb_flatten_serializer.sv
// Self-checking bench for flatten_serializer. Two instances (ORDER=0 and ORDER=1) share stimulus
// and are compared against a queue-of-vectors reference model, directed tables and corner sequences.
module tb_flatten_serializer;

  localparam int CH = 32;
  localparam int DW = 8;
  localparam int IW = 5;

  typedef logic [CH*DW-1:0] vec_t;

  typedef struct {
    bit iv;
    bit sel;
    bit ordy;
    bit e_valid;
    bit e_in_ready;
    bit e_last;
    int e_idx0;
    int e_data0;
    int e_idx1;
    int e_data1;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  vec_t          in_data;
  logic          out_ready;

  logic          in_ready0, out_valid0, out_last0, overflow0, busy0;
  logic [DW-1:0] out_data0;
  logic [IW-1:0] out_idx0;
  logic          in_ready1, out_valid1, out_last1, overflow1, busy1;
  logic [DW-1:0] out_data1;
  logic [IW-1:0] out_idx1;

  flatten_serializer #(.CH(CH), .DATA_W(DW), .ORDER(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_idx(out_idx0),
    .out_last(out_last0), .overflow(overflow0), .busy(busy0)
  );

  flatten_serializer #(.CH(CH), .DATA_W(DW), .ORDER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_idx(out_idx1),
    .out_last(out_last1), .overflow(overflow1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int   n_vec    = 0;
  int   n_err    = 0;
  int   ovf_seen = 0;
  vec_t mq[$];
  int   pos      = 0;
  bit   ovf_exp  = 1'b0;
  rec_t tab[66];
  rec_t cur;
  bit   tab_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkvec(input int base);
    vec_t v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = DW'(k + base);
    return v;
  endfunction

  function automatic vec_t rndvec();
    vec_t v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic drive(input bit iv, input vec_t d, input bit ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic chk_reset();
    chk("rst_valid0", out_valid0, 0);  chk("rst_valid1", out_valid1, 0);
    chk("rst_last0", out_last0, 0);    chk("rst_last1", out_last1, 0);
    chk("rst_inrdy0", in_ready0, 1);   chk("rst_inrdy1", in_ready1, 1);
    chk("rst_busy0", busy0, 0);        chk("rst_busy1", busy1, 0);
    chk("rst_ovf0", overflow0, 0);     chk("rst_ovf1", overflow1, 0);
    chk("rst_idx0", out_idx0, 0);      chk("rst_idx1", out_idx1, CH - 1);
    chk("rst_data0", out_data0, 0);    chk("rst_data1", out_data1, 0);
  endtask

  // Reference: a FIFO of at most two pending vectors; pos counts beats taken from the head.
  task automatic model_check();
    bit   v;
    vec_t h;
    int   r;
    v = (mq.size() != 0);
    chk("valid0", out_valid0, v);            chk("valid1", out_valid1, v);
    chk("busy0", busy0, v);                  chk("busy1", busy1, v);
    chk("in_ready0", in_ready0, mq.size() < 2);
    chk("in_ready1", in_ready1, mq.size() < 2);
    chk("overflow0", overflow0, ovf_exp);    chk("overflow1", overflow1, ovf_exp);
    chk("last0", out_last0, v && pos == CH - 1);
    chk("last1", out_last1, v && pos == CH - 1);
    if (v) begin
      h = mq[0];
      r = CH - 1 - pos;
      chk("idx0", out_idx0, pos);
      chk("data0", out_data0, h[pos*DW +: DW]);
      chk("idx1", out_idx1, r);
      chk("data1", out_data1, h[r*DW +: DW]);
    end
    if (overflow0 === 1'b1) ovf_seen++;
  endtask

  task automatic model_update();
    bit acc;
    acc = in_valid && (mq.size() < 2);
    if (mq.size() != 0 && out_ready) begin
      pos++;
      if (pos == CH) begin
        void'(mq.pop_front());
        pos = 0;
      end
    end
    if (acc) mq.push_back(in_data);
    ovf_exp = in_valid && !acc;
  endtask

  task automatic model_reset();
    mq.delete();
    pos     = 0;
    ovf_exp = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (tab_en) begin
      chk("tab_valid", out_valid0, cur.e_valid);
      chk("tab_in_ready", in_ready0, cur.e_in_ready);
      chk("tab_last", out_last1, cur.e_last);
      chk("tab_ovf", overflow0, 0);
      if (cur.e_valid) begin
        chk("tab_idx0", out_idx0, cur.e_idx0);
        chk("tab_data0", out_data0, cur.e_data0);
        chk("tab_idx1", out_idx1, cur.e_idx1);
        chk("tab_data1", out_data1, cur.e_data1);
      end
    end
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ping-pong table: A (k+1) then B (k+101) back to back; row i>=1 is beat t=i-1.
    for (int i = 0; i < 66; i++) begin
      int t, base;
      tab[i].iv   = (i < 2);
      tab[i].sel  = (i == 1);
      tab[i].ordy = 1'b1;
      if (i == 0) begin
        tab[i].e_valid = 0; tab[i].e_in_ready = 1; tab[i].e_last = 0;
        tab[i].e_idx0 = 0; tab[i].e_data0 = 0; tab[i].e_idx1 = 0; tab[i].e_data1 = 0;
      end else begin
        t = i - 1;
        base = (t < 32) ? 1 : 101;
        tab[i].e_valid    = (t < 64);
        tab[i].e_in_ready = !(t >= 1 && t <= 31);
        tab[i].e_last     = (t < 64) && (t % 32 == 31);
        tab[i].e_idx0     = t % 32;
        tab[i].e_data0    = base + t % 32;
        tab[i].e_idx1     = 31 - t % 32;
        tab[i].e_data1    = base + 31 - t % 32;
      end
    end
    for (int i = 0; i < 66; i++) begin
      cur = tab[i];
      drive(cur.iv, cur.sel ? mkvec(101) : mkvec(1), cur.ordy);
      tab_en = 1'b1;
      tick();
    end
    tab_en = 1'b0;

    // Basic single vector.
    drive(1'b1, mkvec(1), 1'b1); tick();
    drive(1'b0, '0, 1'b1);
    repeat (34) tick();

    // Overflow: A, B fill both banks while stalled, C is dropped; then D, E drop back to back.
    ovf_seen = 0;
    drive(1'b1, mkvec(1), 1'b0);   tick();
    drive(1'b1, mkvec(101), 1'b0); tick();
    drive(1'b1, mkvec(201), 1'b0); tick();
    drive(1'b0, '0, 1'b0);
    repeat (3) tick();
    chk("ovf_once", ovf_seen, 1);
    drive(1'b1, mkvec(150), 1'b0); tick();
    drive(1'b1, mkvec(160), 1'b0); tick();
    drive(1'b0, '0, 1'b0);
    repeat (3) tick();
    chk("ovf_total", ovf_seen, 3);
    drive(1'b0, '0, 1'b1);
    repeat (66) tick();

    // Backpressure: out_ready pattern 1,0,0 repeating.
    for (int i = 0; i < 110; i++) begin
      drive(i == 0, mkvec(51), (i % 3) == 0);
      tick();
    end

    // Reset at beat 10, then a fresh vector.
    drive(1'b1, mkvec(1), 1'b1); tick();
    drive(1'b0, '0, 1'b1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1 chk_reset();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, mkvec(61), 1'b1); tick();
    drive(1'b0, '0, 1'b1);
    repeat (34) tick();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 5) == 0, rndvec(), $urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    repeat (70) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
